// File: rtl/regfile_read_port.sv
// Dual read port for the 32 x 64-bit register file, each port with a one-entry registered output stage.
// Latency: a request accepted at edge N shows its data on rsp_data right after edge N; one request per cycle per port.
// Backpressure: in FULL, req_ready follows rsp_ready; a stalled entry holds its data.
// Optional macro REGFILE_READ_FORWARD_EN: bypasses the write port into capture and refreshes stalled entries.
// X31 (XZR) reads as zero. Addresses outside the register range also read as zero.
module regfile_read_port #(
  parameter int WIDTH    = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 31
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REGS*WIDTH-1:0] reg_bus,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      a_req_valid,
  output logic                      a_req_ready,
  input  logic [ADDR_W-1:0]         a_req_addr,
  output logic                      a_rsp_valid,
  input  logic                      a_rsp_ready,
  output logic [WIDTH-1:0]          a_rsp_data,
  input  logic                      b_req_valid,
  output logic                      b_req_ready,
  input  logic [ADDR_W-1:0]         b_req_addr,
  output logic                      b_rsp_valid,
  input  logic                      b_rsp_ready,
  output logic [WIDTH-1:0]          b_rsp_data
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // Storage lookup. An address that matches no register falls through to zero.
  function automatic logic [WIDTH-1:0] lookup(input logic [ADDR_W-1:0]         addr,
                                              input logic [NUM_REGS*WIDTH-1:0] bus);
    logic [WIDTH-1:0] val;
    val = '0;
    if (addr != ZERO_ADDR) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr == ADDR_W'(i)) val = bus[i*WIDTH +: WIDTH];
      end
    end
    return val;
  endfunction

  logic [0:0]       a_state, b_state;
  logic             a_accept, b_accept;
  logic [WIDTH-1:0] a_cap_data, b_cap_data;

`ifdef REGFILE_READ_FORWARD_EN
  // Writes to XZR never bypass and never refresh a held entry.
  logic              wr_fwd;
  logic [ADDR_W-1:0] a_held_addr, b_held_addr;
  assign wr_fwd = wr_en && (wr_addr != ZERO_ADDR);
`else
  // The write port only matters when forwarding is built in.
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  // EMPTY always accepts. FULL accepts only when the held entry drains this cycle.
  assign a_req_ready = (a_state == S_EMPTY) || a_rsp_ready;
  assign b_req_ready = (b_state == S_EMPTY) || b_rsp_ready;
  assign a_accept    = a_req_valid && a_req_ready;
  assign b_accept    = b_req_valid && b_req_ready;
  assign a_rsp_valid = (a_state == S_FULL);
  assign b_rsp_valid = (b_state == S_FULL);

  // Port A capture value: storage, or same-cycle write data when bypass is enabled.
  always_comb begin
    a_cap_data = lookup(a_req_addr, reg_bus);
`ifdef REGFILE_READ_FORWARD_EN
    if (wr_fwd && (wr_addr == a_req_addr)) a_cap_data = wr_data;
`endif
  end

  // Port B capture value: same selection as port A.
  always_comb begin
    b_cap_data = lookup(b_req_addr, reg_bus);
`ifdef REGFILE_READ_FORWARD_EN
    if (wr_fwd && (wr_addr == b_req_addr)) b_cap_data = wr_data;
`endif
  end

  // Port A output stage FSM. Reset discards any held entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_state    <= S_EMPTY;
      a_rsp_data <= '0;
`ifdef REGFILE_READ_FORWARD_EN
      a_held_addr <= '0;
`endif
    end else if (a_accept) begin
      a_state    <= S_FULL;
      a_rsp_data <= a_cap_data;
`ifdef REGFILE_READ_FORWARD_EN
      a_held_addr <= a_req_addr;
`endif
    end else if ((a_state == S_FULL) && a_rsp_ready) begin
      a_state <= S_EMPTY;
`ifdef REGFILE_READ_FORWARD_EN
    end else if ((a_state == S_FULL) && wr_fwd && (wr_addr == a_held_addr)) begin
      a_rsp_data <= wr_data;
`endif
    end
  end

  // Port B output stage FSM. Same behaviour as port A.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_state    <= S_EMPTY;
      b_rsp_data <= '0;
`ifdef REGFILE_READ_FORWARD_EN
      b_held_addr <= '0;
`endif
    end else if (b_accept) begin
      b_state    <= S_FULL;
      b_rsp_data <= b_cap_data;
`ifdef REGFILE_READ_FORWARD_EN
      b_held_addr <= b_req_addr;
`endif
    end else if ((b_state == S_FULL) && b_rsp_ready) begin
      b_state <= S_EMPTY;
`ifdef REGFILE_READ_FORWARD_EN
    end else if ((b_state == S_FULL) && wr_fwd && (wr_addr == b_held_addr)) begin
      b_rsp_data <= wr_data;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port: vector table plus hand-written reset-during-stall sequence.
module tb_regfile_read_port;

`ifdef REGFILE_READ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [2047:0] reg_bus;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [63:0]   wr_data;
  logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [4:0]    a_req_addr;
  logic [63:0]   a_rsp_data;
  logic          b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [4:0]    b_req_addr;
  logic [63:0]   b_rsp_data;

  logic [63:0] regs [32];

  int n_total  = 0;
  int n_passed = 0;

  regfile_read_port dut (
    .clk(clk), .reset(reset), .reg_bus(reg_bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_addr(a_req_addr),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_val(input int i);
    return {32'hC0DE_0000, i[31:0]};
  endfunction

  // Register storage model: captures the write port at the same edge the DUT samples reg_bus.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    reg_bus = '0;
    for (int i = 0; i < 32; i++) reg_bus[i*64 +: 64] = regs[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        av; logic [4:0] aa; logic ar;
    logic        bv; logic [4:0] ba; logic br;
    logic        we; logic [4:0] wa; logic [63:0] wd;
    logic        e_ardy, e_brdy;
    logic        e_av; logic [63:0] e_ad;
    logic        e_bv; logic [63:0] e_bd;
  } vec_t;

  function automatic vec_t mk(input logic av, input logic [4:0] aa, input logic ar,
                              input logic bv, input logic [4:0] ba, input logic br,
                              input logic we, input logic [4:0] wa, input logic [63:0] wd,
                              input logic e_ardy, input logic e_brdy,
                              input logic e_av, input logic [63:0] e_ad,
                              input logic e_bv, input logic [63:0] e_bd);
    vec_t v;
    v = '{av, aa, ar, bv, ba, br, we, wa, wd, e_ardy, e_brdy, e_av, e_ad, e_bv, e_bd};
    return v;
  endfunction

  vec_t vecs [18];

  initial begin
    // Columns: A{valid,addr,rsp_ready} B{valid,addr,rsp_ready} W{en,addr,data}
    //          pre-edge {a_req_ready,b_req_ready} post-edge {a_valid,a_data,b_valid,b_data}
    vecs[0]  = mk(0,0,1, 0,0,1, 1,5,64'hDEAD_BEEF_0000_0005, 1,1, 0,0, 0,0);
    vecs[1]  = mk(1,5,1, 1,31,1, 0,0,0, 1,1, 1,64'hDEAD_BEEF_0000_0005, 1,0);
    vecs[2]  = mk(0,0,1, 0,0,1, 0,0,0, 1,1, 0,0, 0,0);
    vecs[3]  = mk(1,7,1, 1,2,1, 0,0,0, 1,1, 1,init_val(7), 1,init_val(2));
    vecs[4]  = mk(1,8,0, 0,0,1, 0,0,0, 0,1, 1,init_val(7), 0,0);
    vecs[5]  = mk(1,8,0, 1,6,1, 1,8,64'h8888_8888, 0,1, 1,init_val(7), 1,init_val(6));
    vecs[6]  = mk(1,8,0, 0,0,1, 0,0,0, 0,1, 1,init_val(7), 0,0);
    vecs[7]  = mk(1,8,0, 0,0,1, 0,0,0, 0,1, 1,init_val(7), 0,0);
    vecs[8]  = mk(1,8,1, 0,0,1, 0,0,0, 1,1, 1,64'h8888_8888, 0,0);
    vecs[9]  = mk(0,0,1, 0,0,1, 0,0,0, 1,1, 0,0, 0,0);
    vecs[10] = mk(1,3,1, 0,0,1, 1,3,64'h1234, 1,1, 1,(FWD ? 64'h1234 : init_val(3)), 0,0);
    vecs[11] = mk(1,3,1, 1,3,1, 0,0,0, 1,1, 1,64'h1234, 1,64'h1234);
    vecs[12] = mk(1,31,1, 0,0,1, 1,31,64'hFFFF, 1,1, 1,0, 0,0);
    vecs[13] = mk(1,9,1, 0,0,1, 0,0,0, 1,1, 1,init_val(9), 0,0);
    vecs[14] = mk(0,0,0, 0,0,1, 1,9,64'hABCD, 0,1, 1,(FWD ? 64'hABCD : init_val(9)), 0,0);
    vecs[15] = mk(0,0,0, 0,0,1, 1,10,64'h5555, 0,1, 1,(FWD ? 64'hABCD : init_val(9)), 0,0);
    vecs[16] = mk(0,0,1, 0,0,1, 0,0,0, 1,1, 0,0, 0,0);
    vecs[17] = mk(1,9,1, 0,0,1, 0,0,0, 1,1, 1,64'hABCD, 0,0);

    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    a_req_valid = 1'b0; a_req_addr = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset a_rsp_valid", 64'(a_rsp_valid), 64'd0);
    check("reset b_rsp_valid", 64'(b_rsp_valid), 64'd0);
    check("reset a_rsp_data",  a_rsp_data, 64'd0);
    check("reset b_rsp_data",  b_rsp_data, 64'd0);
    check("reset a_req_ready", 64'(a_req_ready), 64'd1);
    check("reset b_req_ready", 64'(b_req_ready), 64'd1);

    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (i != 0) @(negedge clk);
      a_req_valid = vecs[i].av; a_req_addr = vecs[i].aa; a_rsp_ready = vecs[i].ar;
      b_req_valid = vecs[i].bv; b_req_addr = vecs[i].ba; b_rsp_ready = vecs[i].br;
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      #1;
      check($sformatf("v%0d a_req_ready", i), 64'(a_req_ready), 64'(vecs[i].e_ardy));
      check($sformatf("v%0d b_req_ready", i), 64'(b_req_ready), 64'(vecs[i].e_brdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d a_rsp_valid", i), 64'(a_rsp_valid), 64'(vecs[i].e_av));
      if (vecs[i].e_av) check($sformatf("v%0d a_rsp_data", i), a_rsp_data, vecs[i].e_ad);
      check($sformatf("v%0d b_rsp_valid", i), 64'(b_rsp_valid), 64'(vecs[i].e_bv));
      if (vecs[i].e_bv) check($sformatf("v%0d b_rsp_data", i), b_rsp_data, vecs[i].e_bd);
    end

    // Reset while port A is FULL and stalled: the held entry must vanish.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_addr = 5'd4; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
    check("rst_stall capture valid", 64'(a_rsp_valid), 64'd1);
    check("rst_stall capture data",  a_rsp_data, init_val(4));
    @(negedge clk);
    a_req_valid = 1'b0; a_rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_stall held valid", 64'(a_rsp_valid), 64'd1);
    check("rst_stall held data",  a_rsp_data, init_val(4));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_stall after reset valid", 64'(a_rsp_valid), 64'd0);
    check("rst_stall after reset data",  a_rsp_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_stall req_ready", 64'(a_req_ready), 64'd1);
    @(posedge clk); #1;
    check("rst_stall no stale valid", 64'(a_rsp_valid), 64'd0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
